// File: rtl/lb_arbiter_pkg.sv
// Shared types and defaults for the two-master local-bus arbiter.
package lb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam logic [31:0] ERR_DATA_DEF    = 32'hDEADBEEF;
    localparam int unsigned NUM_M           = 2;
    localparam int unsigned TMR_W           = 16;

endpackage

// File: rtl/lb_arbiter_timer.sv
// Read-wait watchdog: counts cycles while started, asserts expire on the
// TIMEOUT_CYC-th counted cycle.
module lb_arbiter_timer
    import lb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_lb,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expire
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)      cnt_d = '0;
        else if (start) cnt_d = cnt_q + 1'b1;
    end

    // First counted cycle sees cnt_q == 0, so the limit compares against N-1.
    assign expire = start && (cnt_q == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lb_arbiter.sv
// Two-master round-robin local-bus arbiter with registered command forwarding.
// Optional read timeout enabled by defining LB_ARBITER_TIMEOUT_EN.
module lb_arbiter
    import lb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic        reset,
    input  logic        clk_lb,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic        m0_rd,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wr_d,
    output logic        m0_gnt,
    output logic [31:0] m0_rd_d,
    output logic        m0_rd_rdy,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic        m1_rd,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wr_d,
    output logic        m1_gnt,
    output logic [31:0] m1_rd_d,
    output logic        m1_rd_rdy,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy
);

    logic [NUM_M-1:0]       m_req, m_wr, m_rd;
    logic [NUM_M-1:0][31:0] m_addr, m_wdat;

    assign m_req  = {m1_req, m0_req};
    assign m_wr   = {m1_wr, m0_wr};
    assign m_rd   = {m1_rd, m0_rd};
    assign m_addr = {m1_addr, m0_addr};
    assign m_wdat = {m1_wr_d, m0_wr_d};

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic [NUM_M-1:0]       gnt_q, gnt_d;
    logic                   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [31:0]            cmd_addr_q, cmd_addr_d, cmd_wdat_q, cmd_wdat_d;
    logic [NUM_M-1:0]       rd_rdy_q, rd_rdy_d;
    logic [NUM_M-1:0][31:0] rd_d_q, rd_d_d;
    logic                   tmo_expire;
    logic                   rd_done;
    logic [31:0]            rd_data;

`ifdef LB_ARBITER_TIMEOUT_EN
    lb_arbiter_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk_lb (clk_lb),
        .reset  (reset),
        .start  (state_q == ST_RD_WAIT),
        .clear  (state_q != ST_RD_WAIT),
        .expire (tmo_expire)
    );
`else
    logic [15:0] cfg_unused;
    assign cfg_unused = 16'(TIMEOUT_CYC);
    assign tmo_expire = 1'b0;
`endif

    // A real response in the expiry cycle takes precedence over ERR_DATA.
    assign rd_done = lb_rd_rdy || tmo_expire;
    assign rd_data = lb_rd_rdy ? lb_rd_d : ERR_DATA;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        cmd_wr_d   = 1'b0;
        cmd_rd_d   = 1'b0;
        cmd_addr_d = cmd_addr_q;
        cmd_wdat_d = cmd_wdat_q;
        rd_rdy_d   = '0;
        rd_d_d     = rd_d_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    owner_d        = (m_req == 2'b11) ? ~last_q : m_req[1];
                    last_d         = owner_d;
                    gnt_d          = '0;
                    gnt_d[owner_d] = 1'b1;
                    state_d        = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!m_req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (m_wr[owner_q] || m_rd[owner_q]) begin
                    cmd_wr_d   = m_wr[owner_q];
                    cmd_rd_d   = m_rd[owner_q];
                    cmd_addr_d = m_addr[owner_q];
                    if (m_wr[owner_q]) cmd_wdat_d = m_wdat[owner_q];
                    if (m_rd[owner_q]) state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rd_done) begin
                    rd_rdy_d[owner_q] = 1'b1;
                    rd_d_d[owner_q]   = rd_data;
                    state_d           = ST_OWN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            gnt_q      <= '0;
            cmd_wr_q   <= 1'b0;
            cmd_rd_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_wdat_q <= '0;
            rd_rdy_q   <= '0;
            rd_d_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_rd_q   <= cmd_rd_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_wdat_q <= cmd_wdat_d;
            rd_rdy_q   <= rd_rdy_d;
            rd_d_q     <= rd_d_d;
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rd_rdy = rd_rdy_q[0];
    assign m1_rd_rdy = rd_rdy_q[1];
    assign m0_rd_d   = rd_d_q[0];
    assign m1_rd_d   = rd_d_q[1];
    assign lb_wr     = cmd_wr_q;
    assign lb_rd     = cmd_rd_q;
    assign lb_addr   = cmd_addr_q;
    assign lb_wr_d   = cmd_wdat_q;

endmodule
